// File: rtl/return_addr_stack.sv
// Call/return address stack: push stores a return PC, top_addr is read combinationally
// so a return can load PC and pop on the same edge. Sticky overflow/underflow flags.
module return_addr_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clear_err,
  output logic [ADDR_W-1:0] top_addr,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  depth,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  sp_reg, sp_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;
  logic              mem_we;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              is_empty, is_full;

  assign is_empty = (sp_reg == '0);
  assign is_full  = (sp_reg == CNT_W'(DEPTH));
  assign top_idx  = IDX_W'(sp_reg - CNT_W'(1));

  always_comb begin
    sp_next        = sp_reg;
    overflow_next  = clear_err ? 1'b0 : overflow_reg;
    underflow_next = clear_err ? 1'b0 : underflow_reg;
    mem_we         = 1'b0;
    wr_idx         = IDX_W'(sp_reg);
    case ({push, pop})
      2'b10: begin
        if (is_full) begin
          overflow_next = 1'b1;
        end else begin
          mem_we  = 1'b1;
          sp_next = sp_reg + CNT_W'(1);
        end
      end
      2'b01: begin
        if (is_empty) underflow_next = 1'b1;
        else          sp_next        = sp_reg - CNT_W'(1);
      end
      2'b11: begin
        // Simultaneous call/return replaces the top; on an empty stack it is a plain push.
        mem_we = 1'b1;
        if (is_empty) sp_next = CNT_W'(1);
        else          wr_idx  = top_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= push_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      sp_reg        <= sp_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Stale entries stay in mem after a pop, so the empty case must be masked.
  assign top_addr  = is_empty ? '0 : mem[top_idx];
  assign empty     = is_empty;
  assign full      = is_full;
  assign depth     = sp_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: queue-based reference model compared every cycle,
// plus directed literal expectations from the test plan.
module tb_return_addr_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0, pop = 1'b0, clear_err = 1'b0;
  logic [11:0] push_addr = '0;
  logic [11:0] top_addr;
  logic        empty, full, overflow, underflow;
  logic [3:0]  depth;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit cmp_en    = 1'b0;

  logic [11:0] q[$];
  bit          m_ovf, m_unf;

  return_addr_stack #(.ADDR_W(12), .DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
    .clear_err(clear_err), .top_addr(top_addr), .empty(empty), .full(full),
    .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a bounded LIFO of return addresses.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (clear_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (push && pop) begin
        if (q.size() == 0) q.push_back(push_addr);
        else               q[q.size()-1] = push_addr;
      end else if (push) begin
        if (q.size() < 8) q.push_back(push_addr);
        else              m_ovf = 1'b1;
      end else if (pop) begin
        if (q.size() > 0) void'(q.pop_back());
        else              m_unf = 1'b1;
      end
    end
  end

  function automatic int model_top();
    return (q.size() == 0) ? 0 : int'(q[q.size()-1]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_depth",     int'(depth),     q.size());
      check("cmp_top",       int'(top_addr),  model_top());
      check("cmp_empty",     int'(empty),     int'(q.size() == 0));
      check("cmp_full",      int'(full),      int'(q.size() == 8));
      check("cmp_overflow",  int'(overflow),  int'(m_ovf));
      check("cmp_underflow", int'(underflow), int'(m_unf));
    end
  end

  // Drive one cycle of inputs, applied at the next rising edge.
  task automatic cyc(input bit p, input bit o, input logic [11:0] a, input bit c);
    @(negedge clk);
    push = p; pop = o; push_addr = a; clear_err = c;
    $display("cyc push=%0b pop=%0b addr=0x%03h clr=%0b depth=%0d top=0x%03h", p, o, a, c, depth, top_addr);
  endtask

  // Return inputs to idle; outputs now reflect the previous edge.
  task automatic idle();
    cyc(1'b0, 1'b0, 12'h000, 1'b0);
    #1;
  endtask

  initial begin
    #1;
    check("reset_depth", int'(depth), 0);
    check("reset_empty", int'(empty), 1);
    check("reset_top",   int'(top_addr), 0);
    check("reset_full",  int'(full), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;

    // 1: three pushes
    cyc(1, 0, 12'h010, 0);
    cyc(1, 0, 12'h020, 0);
    cyc(1, 0, 12'h030, 0);
    idle();
    check("t1_depth", int'(depth), 3);
    check("t1_top",   int'(top_addr), 'h030);
    check("t1_empty", int'(empty), 0);
    check("t1_full",  int'(full), 0);

    // 2: pop to empty, then underflow
    cyc(0, 1, 0, 0); idle(); check("t2_top1", int'(top_addr), 'h020);
    cyc(0, 1, 0, 0); idle(); check("t2_top2", int'(top_addr), 'h010);
    cyc(0, 1, 0, 0); idle(); check("t2_top3", int'(top_addr), 'h000);
    check("t2_empty", int'(empty), 1);
    check("t2_unf0",  int'(underflow), 0);
    cyc(0, 1, 0, 0); idle();
    check("t2_unf1",  int'(underflow), 1);
    check("t2_depth", int'(depth), 0);

    // 3: fill, overflow, drain
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 12'(12'h100 + i), 0);
    cyc(1, 0, 12'h1FF, 0);
    idle();
    check("t3_full",  int'(full), 1);
    check("t3_depth", int'(depth), 8);
    check("t3_ovf",   int'(overflow), 1);
    check("t3_top",   int'(top_addr), 'h107);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0); idle();
      check("t3_drain", int'(top_addr), (i == 7) ? 0 : ('h106 - i));
    end

    // 4: replace-top and push+pop on empty
    cyc(0, 0, 0, 1);
    cyc(1, 0, 12'h010, 0);
    cyc(1, 0, 12'h020, 0);
    cyc(1, 1, 12'h0AB, 0);
    idle();
    check("t4_depth", int'(depth), 2);
    check("t4_top",   int'(top_addr), 'h0AB);
    check("t4_flags", int'({overflow, underflow}), 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 12'h055, 0);
    idle();
    check("t4e_depth", int'(depth), 1);
    check("t4e_top",   int'(top_addr), 'h055);
    check("t4e_unf",   int'(underflow), 0);

    // 4b: replace-top while full raises no flag
    for (int i = 0; i < 7; i++) cyc(1, 0, 12'(12'h200 + i), 0);
    cyc(1, 1, 12'h2EE, 0);
    idle();
    check("t4f_top", int'(top_addr), 'h2EE);
    check("t4f_ovf", int'(overflow), 0);

    // 5: clear_err alone, then clear_err racing an overflow
    cyc(1, 0, 12'h333, 0); idle();
    check("t5_ovf_set", int'(overflow), 1);
    cyc(0, 0, 0, 1); idle();
    check("t5_ovf_clr", int'(overflow), 0);
    cyc(1, 0, 12'h222, 1); idle();
    check("t5_ovf_win", int'(overflow), 1);
    check("t5_top",     int'(top_addr), 'h2EE);

    // 6: asynchronous reset mid-operation
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    idle();
    check("t6_depth5", int'(depth), 5);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_depth", int'(depth), 0);
    check("t6_rst_empty", int'(empty), 1);
    check("t6_rst_top",   int'(top_addr), 0);
    check("t6_rst_flags", int'({overflow, underflow}), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 0, 12'h3C3, 0);
    idle();
    check("t6_depth", int'(depth), 1);
    check("t6_top",   int'(top_addr), 'h3C3);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
